// File: rtl/nor_flash_model.sv
// ---------------------------------------------------------------------------
// nor_flash_model
//   Clocked behavioural model of a parallel NOR flash. Decodes the JEDEC
//   unlock sequences for word program and sector erase, holds the part busy
//   for a programmable number of cycles and answers reads with either array
//   contents or DQ7/DQ6 polling status.
//
// Ports
//   clk_i        clock; every bus pin is sampled on the rising edge
//   rst_ni       asynchronous reset, active low (array contents survive it)
//   nor_ce_ni    chip enable, active low
//   nor_we_ni    write enable, active low
//   nor_oe_ni    output enable, active low
//   nor_addr_i   word address (aliases modulo 2**DEPTH_W)
//   nor_data_i   write data from the controller
//   nor_data_o   read data / polling status, one cycle after the read sample
//   nor_data_oe  model drives the bus
//   nor_ry_o     ready (1) / busy (0)
//   busy_cnt_o   remaining busy cycles
// ---------------------------------------------------------------------------
module nor_flash_model #(
  parameter int ADDR_W   = 26,
  parameter int DATA_W   = 16,
  parameter int DEPTH_W  = 12,
  parameter int SECTOR_W = 8,
  parameter int T_PROG   = 16,
  parameter int T_ERASE  = 512
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              nor_ce_ni,
  input  logic              nor_we_ni,
  input  logic              nor_oe_ni,
  input  logic [ADDR_W-1:0] nor_addr_i,
  input  logic [DATA_W-1:0] nor_data_i,
  output logic [DATA_W-1:0] nor_data_o,
  output logic              nor_data_oe,
  output logic              nor_ry_o,
  output logic [15:0]       busy_cnt_o
);

  localparam int DEPTH      = 1 << DEPTH_W;
  localparam int SECT_WORDS = 1 << SECTOR_W;

  // Erase clears one word per busy cycle, so the busy window must cover a sector.
  if (T_ERASE < SECT_WORDS) begin : g_bad_erase_time
    $error("nor_flash_model: T_ERASE shorter than words per sector");
  end
  if (T_PROG < 1) begin : g_bad_prog_time
    $error("nor_flash_model: T_PROG must be at least 1");
  end
  if (DATA_W < 8) begin : g_bad_data_w
    $error("nor_flash_model: DATA_W must be at least 8");
  end
  if (SECTOR_W >= DEPTH_W) begin : g_bad_sector_w
    $error("nor_flash_model: SECTOR_W must be below DEPTH_W");
  end

  typedef enum logic [3:0] {
    ST_IDLE, ST_C1, ST_C2, ST_PROG, ST_E1, ST_E2, ST_E3, ST_BUSY_P, ST_BUSY_E
  } state_t;

  // Array powers up erased and is deliberately left out of reset.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '1};

  logic                  we_n_p1, oe_n_p1;
  logic [ADDR_W-1:0]     lat_addr;
  logic [DATA_W-1:0]     lat_data;
  logic                  wr_evt, is_555, is_2aa;
  logic [7:0]            cmd;
  state_t                state_q, state_d;
  logic [15:0]           cnt_q;
  logic                  busy, start_prog, start_erase;
  logic                  prog_bit7;
  logic [DEPTH_W-SECTOR_W-1:0] ers_sector;
  logic [15:0]           ers_k;
  logic                  ers_we;
  logic [DEPTH_W-1:0]    ers_addr, prog_addr, rd_addr;
  logic                  rd_en, new_rd, tgl_q;
  logic [DATA_W-1:0]     status;
  logic [DATA_W-1:0]     rd_data_p1;
  logic                  vld_p1;
  logic                  unused_bits;

  // ---- stage 0: bus decode --------------------------------------------------
  // A write completes on the rising edge of we_n while the chip stays selected.
  assign wr_evt    = !we_n_p1 && nor_we_ni && !nor_ce_ni;
  assign is_555    = (lat_addr[11:0] == 12'h555);
  assign is_2aa    = (lat_addr[11:0] == 12'h2AA);
  assign cmd       = lat_data[7:0];
  assign prog_addr = lat_addr[DEPTH_W-1:0];
  assign rd_addr   = nor_addr_i[DEPTH_W-1:0];
  assign rd_en     = !nor_ce_ni && !nor_oe_ni && nor_we_ni;
  assign new_rd    = rd_en && oe_n_p1;

  assign start_prog  = (state_q == ST_PROG) && (state_d == ST_BUSY_P);
  assign start_erase = (state_q == ST_E3)   && (state_d == ST_BUSY_E);

  // Busy cycle index k since the erase started; word k is cleared in cycle k.
  assign ers_k    = 16'(T_ERASE - 1) - cnt_q;
  assign ers_we   = (state_q == ST_BUSY_E) && (ers_k < 16'(SECT_WORDS));
  assign ers_addr = {ers_sector, ers_k[SECTOR_W-1:0]};

  assign unused_bits = ^{lat_addr, nor_addr_i};

  always_ff @(posedge clk_i) begin
    if (!nor_ce_ni && !nor_we_ni) begin
      lat_addr <= nor_addr_i;
      lat_data <= nor_data_i;
    end
    if (start_prog)  prog_bit7  <= lat_data[7];
    if (start_erase) ers_sector <= lat_addr[DEPTH_W-1:SECTOR_W];
  end

  // ---- FSM: state register --------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // ---- FSM: next state ------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BUSY_P, ST_BUSY_E: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
      default: begin
        if (wr_evt) begin
          state_d = ST_IDLE;
          if (cmd != 8'hF0) begin
            case (state_q)
              ST_IDLE: if (is_555 && cmd == 8'hAA) state_d = ST_C1;
              ST_C1:   if (is_2aa && cmd == 8'h55) state_d = ST_C2;
              ST_C2:   if (is_555 && cmd == 8'hA0) state_d = ST_PROG;
                       else if (is_555 && cmd == 8'h80) state_d = ST_E1;
              ST_PROG: state_d = ST_BUSY_P;
              ST_E1:   if (is_555 && cmd == 8'hAA) state_d = ST_E2;
              ST_E2:   if (is_2aa && cmd == 8'h55) state_d = ST_E3;
              ST_E3:   if (cmd == 8'h30) state_d = ST_BUSY_E;
              default: state_d = ST_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // ---- FSM: outputs ---------------------------------------------------------
  always_comb begin
    busy      = (state_q == ST_BUSY_P) || (state_q == ST_BUSY_E);
    status    = '0;
    status[7] = (state_q == ST_BUSY_P) ? ~prog_bit7 : 1'b0;
    // The read that starts a new access already sees the inverted toggle.
    status[6] = tgl_q ^ new_rd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          cnt_q <= '0;
    else if (start_prog)  cnt_q <= 16'(T_PROG - 1);
    else if (start_erase) cnt_q <= 16'(T_ERASE - 1);
    else if (busy && cnt_q != '0) cnt_q <= cnt_q - 16'd1;
  end

  // ---- array update ---------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (start_prog)  mem[prog_addr] <= mem[prog_addr] & lat_data;
    else if (ers_we) mem[ers_addr]  <= '1;
  end

  // ---- stage 1: read return -------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_n_p1    <= 1'b1;
      oe_n_p1    <= 1'b1;
      tgl_q      <= 1'b0;
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      we_n_p1 <= nor_we_ni;
      oe_n_p1 <= nor_oe_ni;
      if (busy && new_rd) tgl_q <= ~tgl_q;
      vld_p1 <= rd_en;
      if (!rd_en)    rd_data_p1 <= '0;
      else if (busy) rd_data_p1 <= status;
      else           rd_data_p1 <= mem[rd_addr];
    end
  end

  assign nor_data_o  = rd_data_p1;
  assign nor_data_oe = vld_p1;
  assign nor_ry_o    = ~busy;
  assign busy_cnt_o  = cnt_q;

endmodule

// File: tb/tb_nor_flash_model.sv
module tb_nor_flash_model;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ce_n = 1'b1, we_n = 1'b1, oe_n = 1'b1;
  logic [25:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        data_oe, ry;
  logic [15:0] busy_cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] model [4096];
  logic        tgl_m;
  logic [15:0] exp_q [$];
  string       tag_q [$];

  always #5 clk = ~clk;

  nor_flash_model #(
    .ADDR_W(26), .DATA_W(16), .DEPTH_W(12), .SECTOR_W(8), .T_PROG(16), .T_ERASE(512)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .nor_ce_ni  (ce_n),
    .nor_we_ni  (we_n),
    .nor_oe_ni  (oe_n),
    .nor_addr_i (addr),
    .nor_data_i (wdata),
    .nor_data_o (rdata),
    .nor_data_oe(data_oe),
    .nor_ry_o   (ry),
    .busy_cnt_o (busy_cnt)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One read access: expected value queued at drive, compared when data returns.
  task automatic rd(input logic [25:0] a, input logic [15:0] exp, input string tag);
    logic [15:0] e;
    string t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = a;
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, " oe"}, 32'(data_oe), 32'd1);
    check(t, 32'(rdata), 32'(e));
    oe_n = 1'b1; ce_n = 1'b1;
    @(negedge clk);
    check({t, " oe off"}, 32'(data_oe), 32'd0);
  endtask

  task automatic poll(input logic [25:0] a, input logic dq7, input string tag);
    tgl_m = ~tgl_m;
    rd(a, {8'h00, dq7, tgl_m, 6'b0}, tag);
  endtask

  task automatic bus_write(input logic [25:0] a, input logic [15:0] d);
    addr = a; wdata = d; ce_n = 1'b0; we_n = 1'b0;
    @(negedge clk);
    we_n = 1'b1;
    @(negedge clk);
    ce_n = 1'b1;
  endtask

  task automatic prog_cmd(input logic [25:0] a, input logic [15:0] d);
    bus_write(26'h555, 16'h00AA);
    bus_write(26'h2AA, 16'h0055);
    bus_write(26'h555, 16'h00A0);
    bus_write(a, d);
    model[a[11:0]] = model[a[11:0]] & d;
  endtask

  task automatic erase_cmd(input logic [25:0] a);
    bus_write(26'h555, 16'h00AA);
    bus_write(26'h2AA, 16'h0055);
    bus_write(26'h555, 16'h0080);
    bus_write(26'h555, 16'h00AA);
    bus_write(26'h2AA, 16'h0055);
    bus_write(a, 16'h0030);
  endtask

  task automatic wait_ready(input int max, output int n);
    n = 0;
    while (ry === 1'b0 && n < max) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic [15:0] last;
    for (int i = 0; i < 4096; i++) model[i] = 16'hFFFF;
    tgl_m = 1'b0;

    // Reset with random pins
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ce_n = 1'($urandom); we_n = 1'($urandom); oe_n = 1'($urandom);
      addr = 26'($urandom); wdata = 16'($urandom);
    end
    @(negedge clk);
    check("rst ry", 32'(ry), 32'd1);
    check("rst data_oe", 32'(data_oe), 32'd0);
    check("rst data_o", 32'(rdata), 32'd0);
    check("rst busy_cnt", 32'(busy_cnt), 32'd0);
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    rd(26'h000123, 16'hFFFF, "read 0x123 after reset");

    // Program with polling
    prog_cmd(26'h000040, 16'h1234);
    check("prog ry low", 32'(ry), 32'd0);
    check("prog cnt start", 32'(busy_cnt), 32'd15);
    poll(26'h40, 1'b1, "prog poll1");
    poll(26'h40, 1'b1, "prog poll2");
    poll(26'h40, 1'b1, "prog poll3");
    check("prog cnt mid", 32'(busy_cnt), 32'd9);
    wait_ready(100, n);
    check("prog busy tail", 32'(n), 32'd10);
    check("prog cnt end", 32'(busy_cnt), 32'd0);
    rd(26'h40, 16'h1234, "read 0x40 after 1234");
    prog_cmd(26'h000040, 16'hFF00);
    wait_ready(100, n);
    check("prog2 busy len", 32'(n), 32'd16);
    rd(26'h40, 16'h1200, "read 0x40 after FF00");

    // Sector erase
    prog_cmd(26'h000040, 16'h00FF);
    wait_ready(100, n);
    prog_cmd(26'h0001FF, 16'hA5C3);
    wait_ready(100, n);
    rd(26'h40, model[12'h040], "read 0x40 before erase");
    erase_cmd(26'h000050);
    check("erase ry low", 32'(ry), 32'd0);
    check("erase cnt start", 32'(busy_cnt), 32'd511);
    poll(26'h50, 1'b0, "erase poll");
    check("erase cnt mid", 32'(busy_cnt), 32'd509);
    n = 0; last = 16'hFFFF;
    while (ry === 1'b0 && n < 1000) begin
      last = busy_cnt; n++;
      @(negedge clk);
    end
    check("erase busy tail", 32'(n), 32'd510);
    check("erase last cnt", 32'(last), 32'd0);
    for (int k = 0; k < 256; k++) model[{4'h0, 8'(k)}] = 16'hFFFF;
    rd(26'h40, 16'hFFFF, "erased 0x40");
    rd(26'hFF, model[12'h0FF], "erased 0xFF");
    rd(26'h1FF, 16'hA5C3, "other sector 0x1FF");

    // Abort and ignore
    bus_write(26'h555, 16'h00AA);
    bus_write(26'h2AA, 16'h0000);
    bus_write(26'h2AA, 16'h0055);
    bus_write(26'h555, 16'h00A0);
    bus_write(26'h060, 16'h0000);
    check("mismatch no busy", 32'(ry), 32'd1);
    rd(26'h60, 16'hFFFF, "mismatch no program");
    bus_write(26'h555, 16'h00AA);
    bus_write(26'h2AA, 16'h0055);
    bus_write(26'h555, 16'h00F0);
    bus_write(26'h555, 16'h00A0);
    bus_write(26'h061, 16'h0000);
    check("F0 in C2 no busy", 32'(ry), 32'd1);
    rd(26'h61, 16'hFFFF, "F0 in C2 no program");
    bus_write(26'h555, 16'h00AA);
    bus_write(26'h2AA, 16'h0055);
    bus_write(26'h555, 16'h00A0);
    bus_write(26'h062, 16'h12F0);
    check("F0 in PROG no busy", 32'(ry), 32'd1);
    rd(26'h62, 16'hFFFF, "F0 in PROG no program");
    prog_cmd(26'h000070, 16'h5A5A);
    bus_write(26'h070, 16'h0000);
    bus_write(26'h555, 16'h00F0);
    check("busy write timer", 32'(busy_cnt), 32'd11);
    wait_ready(100, n);
    check("busy write tail", 32'(n), 32'd12);
    rd(26'h70, 16'h5A5A, "busy write no effect");

    // Aliasing
    prog_cmd(26'h001001, 16'h3C3C);
    wait_ready(100, n);
    rd(26'h0001, 16'h3C3C, "alias 0x0001");
    rd(26'h1001, 16'h3C3C, "alias 0x1001");

    // Reset mid-erase
    prog_cmd(26'h200, 16'h1111); wait_ready(100, n);
    prog_cmd(26'h263, 16'h2222); wait_ready(100, n);
    prog_cmd(26'h264, 16'h4444); wait_ready(100, n);
    prog_cmd(26'h2FF, 16'h8888); wait_ready(100, n);
    erase_cmd(26'h000280);
    repeat (100) @(negedge clk);
    check("mid-erase ry low", 32'(ry), 32'd0);
    rst_ni = 1'b0;
    #1;
    check("async reset ry", 32'(ry), 32'd1);
    check("async reset cnt", 32'(busy_cnt), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    tgl_m = 1'b0;
    for (int k = 0; k < 100; k++) model[12'h200 + 12'(k)] = 16'hFFFF;
    @(negedge clk);
    rd(26'h200, 16'hFFFF, "partial erase word0");
    rd(26'h263, 16'hFFFF, "partial erase word99");
    rd(26'h264, 16'h4444, "partial erase word100");
    rd(26'h2FF, model[12'h2FF], "partial erase word255");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
